// File: rtl/parity_req_arbiter_if.sv
// Requester-side and parity-unit-side signals of the shared parity arbiter.
interface parity_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      resp_odd;
  logic                      resp_err;
  logic                      p_start;
  logic [DATA_W-1:0]         p_data_in;
  logic                      p_busy;
  logic                      p_even;
  logic                      p_odd;

  // Environment side: requesters plus the parity unit.
  modport master (
    output req, req_data, p_busy, p_even, p_odd,
    input  grant, done, resp_odd, resp_err, p_start, p_data_in
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, p_busy, p_even, p_odd,
    output grant, done, resp_odd, resp_err, p_start, p_data_in
  );
endinterface

// File: rtl/parity_req_arbiter.sv
// Round-robin arbiter sharing one parity unit among NUM_REQ requesters; it runs the
// start/busy handshake, guards it with a timeout and returns the result with a done pulse.
module parity_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  parity_req_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESPOND   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_idx;
  logic               w_found;
  logic               w_launch;
  logic               w_timeout;
  logic               w_bad;
  logic [CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]  w_bytes [NUM_REQ];
  logic [NUM_REQ-1:0] w_onehot_win;
  logic [NUM_REQ-1:0] w_onehot_ptr;

  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic               r_resp_odd;
  logic               w_resp_odd_nxt;
  logic               r_resp_err;
  logic               w_resp_err_nxt;
  logic               r_p_start;
  logic               w_p_start_nxt;
  logic [DATA_W-1:0]  r_p_data;
  logic [DATA_W-1:0]  w_p_data_nxt;

  // A healthy unit reports exactly one of even/odd.
  function automatic logic flags_bad(input logic even_f, input logic odd_f);
    return ~(even_f ^ odd_f);
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign w_bytes[k] = bus.req_data[k*DATA_W +: DATA_W];
  end

  assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT));
  assign w_launch     = (r_state == S_IDLE) && !bus.p_busy && w_found;
  assign w_bad        = flags_bad(bus.p_even, bus.p_odd);
  assign w_onehot_win = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_onehot_ptr = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_ptr;

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the timeout wins over a late busy edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_state_nxt = S_WAIT_BUSY;
        else          w_state_nxt = S_IDLE;
      end
      S_WAIT_BUSY: begin
        if (w_timeout)       w_state_nxt = S_RESPOND;
        else if (bus.p_busy) w_state_nxt = S_WAIT_DONE;
        else                 w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_DONE: begin
        if (w_timeout || !bus.p_busy) w_state_nxt = S_RESPOND;
        else                          w_state_nxt = S_WAIT_DONE;
      end
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_grant_nxt    = {NUM_REQ{1'b0}};
    w_done_nxt     = {NUM_REQ{1'b0}};
    w_resp_odd_nxt = 1'b0;
    w_resp_err_nxt = 1'b0;
    w_p_start_nxt  = 1'b0;
    w_p_data_nxt   = r_p_data;
    w_ptr_nxt      = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_grant_nxt   = w_onehot_win;
          w_p_start_nxt = 1'b1;
          w_p_data_nxt  = w_bytes[w_win];
          w_ptr_nxt     = w_win;
        end else begin
          w_p_start_nxt = 1'b0;
        end
      end
      S_WAIT_BUSY: begin
        if (w_timeout) begin
          w_done_nxt     = w_onehot_ptr;
          w_resp_err_nxt = 1'b1;
        end else if (bus.p_busy) begin
          w_p_start_nxt = 1'b0;
        end else begin
          w_p_start_nxt = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (w_timeout) begin
          w_done_nxt     = w_onehot_ptr;
          w_resp_err_nxt = 1'b1;
        end else if (!bus.p_busy) begin
          w_done_nxt     = w_onehot_ptr;
          w_resp_err_nxt = w_bad;
          w_resp_odd_nxt = bus.p_odd & ~w_bad;
        end else begin
          w_done_nxt = {NUM_REQ{1'b0}};
        end
      end
      S_RESPOND: w_p_start_nxt = 1'b0;
      default:   w_p_start_nxt = 1'b0;
    endcase
  end

  // Output, pointer and timeout-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant    <= {NUM_REQ{1'b0}};
      r_done     <= {NUM_REQ{1'b0}};
      r_resp_odd <= 1'b0;
      r_resp_err <= 1'b0;
      r_p_start  <= 1'b0;
      r_p_data   <= {DATA_W{1'b0}};
      r_ptr      <= PTR_W'(NUM_REQ - 1);
      r_cnt      <= {CNT_W{1'b0}};
    end else begin
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_resp_odd <= w_resp_odd_nxt;
      r_resp_err <= w_resp_err_nxt;
      r_p_start  <= w_p_start_nxt;
      r_p_data   <= w_p_data_nxt;
      r_ptr      <= w_ptr_nxt;
      if (w_launch) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if ((r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.done      = r_done;
  assign bus.resp_odd  = r_resp_odd;
  assign bus.resp_err  = r_resp_err;
  assign bus.p_start   = r_p_start;
  assign bus.p_data_in = r_p_data;
endmodule

// File: tb/tb_parity_req_arbiter.sv
// Bench for parity_req_arbiter: vector table, hand-written corner sequences, and
// random requesters checked against a transaction-level reference model.
module tb_parity_req_arbiter;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 8;
  localparam int TIMEOUT  = 64;
  localparam int U_REAL   = 0;
  localparam int U_BAD    = 1;
  localparam int U_STUCK0 = 2;
  localparam int U_STUCK1 = 3;

  logic clk = 1'b0;
  logic rst;

  parity_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  parity_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         u_mode = U_REAL;
  int         u_cnt  = 0;
  int         u_len  = 3;
  bit         u_rand = 1'b0;
  logic [7:0] u_byte = 8'h00;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          mode;
    int          win;
    logic        odd;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Parity unit model: busy for u_len cycles after sampling start, flags valid on the fall.
  task automatic unit_update(input logic st, input logic [7:0] by);
    case (u_mode)
      U_STUCK0: begin
        bus.p_busy = 1'b0;
        bus.p_even = 1'b0;
        bus.p_odd  = 1'b0;
      end
      U_STUCK1: bus.p_busy = 1'b1;
      default: begin
        if (u_cnt > 0) begin
          u_cnt--;
          if (u_cnt == 0) begin
            bus.p_busy = 1'b0;
            if (u_mode == U_BAD) begin
              bus.p_even = 1'b1;
              bus.p_odd  = 1'b1;
            end else begin
              bus.p_odd  = ^u_byte;
              bus.p_even = ~^u_byte;
            end
          end
        end else if (st) begin
          bus.p_busy = 1'b1;
          u_byte     = by;
          u_cnt      = u_rand ? int'($urandom_range(4, 1)) : u_len;
        end
      end
    endcase
  endtask

  task automatic tick();
    logic       st;
    logic [7:0] by;
    st = bus.p_start;
    by = bus.p_data_in;
    @(posedge clk);
    #1;
    unit_update(st, by);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    bus.req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int lat;
    bus.req      = v.req;
    bus.req_data = v.data;
    u_mode       = v.mode;
    lat = 0;
    do begin tick(); lat++; end while (bus.grant == 4'b0000 && lat < 20);
    check($sformatf("v%0d_grant_lat", idx), lat, 32'd1);
    check($sformatf("v%0d_grant", idx), bus.grant, 32'd1 << v.win);
    check($sformatf("v%0d_data", idx), bus.p_data_in, (v.data >> (8 * v.win)) & 32'hFF);
    check($sformatf("v%0d_start", idx), bus.p_start, 32'd1);
    bus.req = 4'b0000;
    lat = 0;
    do begin tick(); lat++; end while (bus.done == 4'b0000 && lat < 200);
    check($sformatf("v%0d_done", idx), bus.done, 32'd1 << v.win);
    check($sformatf("v%0d_resp", idx), {bus.resp_odd, bus.resp_err}, {v.odd, v.err});
    tick();
    check($sformatf("v%0d_gap", idx), {bus.grant, bus.done}, 32'd0);
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  initial begin
    int         lat;
    int         cnt;
    int         m_owner;
    int         m_last;
    int         w;
    bit         m_seen;
    bit         m_resp;
    logic [3:0] e_grant;
    logic [3:0] e_done;
    logic       e_start;
    logic       e_odd;
    logic [7:0] e_data;

    vecs[0]  = '{4'b0101, 32'h0003_0001, U_REAL, 0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0101, 32'h0003_0001, U_REAL, 2, 1'b0, 1'b0};
    vecs[2]  = '{4'b0101, 32'h0003_0001, U_REAL, 0, 1'b1, 1'b0};
    vecs[3]  = '{4'b0010, 32'h0000_0700, U_REAL, 1, 1'b1, 1'b0};
    vecs[4]  = '{4'b0010, 32'h0000_0F00, U_REAL, 1, 1'b0, 1'b0};
    vecs[5]  = '{4'b1111, 32'hA580_FF00, U_REAL, 2, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 32'hA580_FF00, U_REAL, 3, 1'b0, 1'b0};
    vecs[7]  = '{4'b1111, 32'hA580_FF00, U_REAL, 0, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 32'hA580_FF00, U_REAL, 1, 1'b0, 1'b0};
    vecs[9]  = '{4'b1111, 32'hA580_FF00, U_REAL, 2, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, 32'hA580_FF00, U_REAL, 3, 1'b0, 1'b0};
    vecs[11] = '{4'b1111, 32'hA580_FF00, U_REAL, 0, 1'b0, 1'b0};
    vecs[12] = '{4'b1111, 32'hA580_FF00, U_REAL, 1, 1'b0, 1'b0};
    vecs[13] = '{4'b1000, 32'h0100_0000, U_BAD,  3, 1'b0, 1'b1};

    rst          = 1'b1;
    bus.req      = 4'b0000;
    bus.req_data = 32'h0;
    bus.p_busy   = 1'b0;
    bus.p_even   = 1'b0;
    bus.p_odd    = 1'b0;
    @(negedge clk);
    reset_dut();
    check("reset_outputs", {bus.grant, bus.done, bus.p_start, bus.p_data_in, bus.resp_odd, bus.resp_err}, 32'd0);

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Unit never raises busy: start is held until the timeout answers with an error.
    u_mode = U_STUCK0;
    bus.req = 4'b0100;
    bus.req_data = 32'h0055_0000;
    lat = 0;
    do begin tick(); lat++; end while (bus.grant == 4'b0000 && lat < 20);
    check("to_grant", bus.grant, 32'h4);
    bus.req = 4'b0000;
    lat = 0;
    cnt = 0;
    do begin
      tick();
      lat++;
      if (bus.done == 4'b0000 && !bus.p_start) cnt++;
    end while (bus.done == 4'b0000 && lat < TIMEOUT + 20);
    check("to_latency", lat, TIMEOUT + 1);
    check("to_start_held", cnt, 32'd0);
    check("to_done", bus.done, 32'h4);
    check("to_resp", {bus.resp_odd, bus.resp_err}, 32'h1);
    check("to_start_clear", bus.p_start, 32'd0);
    tick();

    // Unit stuck busy: nothing may be issued until busy drops.
    u_mode = U_STUCK1;
    bus.p_busy = 1'b1;
    bus.req = 4'b0001;
    bus.req_data = 32'h0000_0001;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.grant != 4'b0000) cnt++;
    end
    check("stuck_no_grant", cnt, 32'd0);
    u_mode = U_REAL;
    u_cnt = 0;
    bus.p_busy = 1'b0;
    run_txn('{4'b0001, 32'h0000_0001, U_REAL, 0, 1'b1, 1'b0}, 99);

    // Reset while waiting for the unit to finish.
    u_len = 20;
    bus.req = 4'b0010;
    bus.req_data = 32'h0000_0703;
    lat = 0;
    do begin tick(); lat++; end while (bus.grant == 4'b0000 && lat < 20);
    check("rst_first_grant", bus.grant, 32'h2);
    bus.req = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    check("rst_pre_start", {bus.p_start, bus.p_busy}, 32'h1);
    rst = 1'b1;
    tick();
    check("rst_outputs", {bus.grant, bus.done, bus.p_start, bus.p_data_in, bus.resp_odd, bus.resp_err}, 32'd0);
    rst = 1'b0;
    lat = 0;
    cnt = 0;
    do begin
      tick();
      lat++;
      if (bus.done != 4'b0000) cnt++;
    end while (bus.grant == 4'b0000 && lat < 60);
    check("rst_no_done", cnt, 32'd0);
    check("rst_regrant", bus.grant, 32'h1);
    bus.req = 4'b0000;
    lat = 0;
    do begin tick(); lat++; end while (bus.done == 4'b0000 && lat < 200);
    check("rst_done", bus.done, 32'h1);
    check("rst_resp", {bus.resp_odd, bus.resp_err}, 32'h0);
    tick();
    u_len = 3;

    // Random requesters against the reference model.
    reset_dut();
    u_rand  = 1'b1;
    u_mode  = U_REAL;
    m_owner = -1;
    m_last  = NUM_REQ - 1;
    m_seen  = 1'b0;
    m_resp  = 1'b0;
    e_grant = 4'b0000;
    e_done  = 4'b0000;
    e_start = 1'b0;
    e_odd   = 1'b0;
    e_data  = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      check("rnd_grant", bus.grant, e_grant);
      check("rnd_done", bus.done, e_done);
      check("rnd_start", bus.p_start, e_start);
      check("rnd_data", bus.p_data_in, e_data);
      if (e_done != 4'b0000) check("rnd_resp", {bus.resp_odd, bus.resp_err}, {e_odd, 1'b0});
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i] && bus.grant[i]) begin
          bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(3, 0) == 0) begin
          bus.req_data[i*8 +: 8] = 8'($urandom);
          bus.req[i] = 1'b1;
        end
      end
      e_grant = 4'b0000;
      e_done  = 4'b0000;
      e_start = 1'b0;
      e_odd   = 1'b0;
      if (m_resp) begin
        m_owner = -1;
        m_resp  = 1'b0;
      end else if (m_owner < 0) begin
        if (!bus.p_busy && bus.req != 4'b0000) begin
          w       = rr_pick(bus.req, m_last);
          e_grant = 4'(1 << w);
          e_start = 1'b1;
          e_data  = bus.req_data[w*8 +: 8];
          m_owner = w;
          m_last  = w;
          m_seen  = 1'b0;
        end
      end else if (!m_seen) begin
        if (bus.p_busy) m_seen = 1'b1;
        else            e_start = 1'b1;
      end else if (!bus.p_busy) begin
        e_done = 4'(1 << m_owner);
        e_odd  = ($countones(e_data) % 2) == 1;
        m_resp = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_req_arbiter.md
Name: parity_req_arbiter

Overview:
- Shares one parity unit (start/data_in/busy/even_parity/odd_parity interface) between NUM_REQ requesters.
- Picks requesters round-robin, latches the winner's byte, and sequences the unit's start/busy handshake.
- Captures the parity result and returns it to the winning requester with a one-cycle done pulse.
- A timeout guards against a stuck unit; sits between requester blocks and the parity datapath/controller pair.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width passed to the parity unit
TIMEOUT, 64, max cycles spent in WAIT_BUSY plus WAIT_DONE before an error response (>=32)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester request level; held until its grant bit is seen
req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, data latched
done  out  NUM_REQ  one-hot, one-cycle pulse: result valid for that requester
resp_odd  out  1  1 = odd number of ones; valid only with done
resp_err  out  1  1 = timeout or inconsistent flags; valid only with done
p_start  out  1  start to parity unit
p_data_in  out  DATA_W  byte to parity unit, stable from grant until done
p_busy  in  1  parity unit busy
p_even  in  1  parity unit even_parity
p_odd  in  1  parity unit odd_parity

Behaviour:
- All outputs are registered. Reset value of every output is 0; state=IDLE; rr pointer=NUM_REQ-1, so req[0] has highest priority first.
- Reset mid-operation returns to IDLE on the next edge. No done is issued for the aborted transaction.
- IDLE:
  - Arbitrates only when p_busy==0.
  - Winner = first asserted req scanning from pointer+1 upward, modulo NUM_REQ.
  - On a winner: latch req_data slice into p_data_in, set pointer=winner, and go to WAIT_BUSY.
  - Next cycle: grant[winner]=1 (single cycle) and p_start=1.
- WAIT_BUSY:
  - Hold p_start=1 until p_busy==1 is sampled.
  - Then clear p_start on the following cycle and go to WAIT_DONE.
- WAIT_DONE:
  - Wait for p_busy==0.
  - On that cycle, sample p_odd/p_even into the result registers and go to RESPOND.
- RESPOND (one cycle), then IDLE:
  - done[winner]=1.
  - resp_odd=p_odd sample.
  - resp_err=1 if the samples were both 1 or both 0; in that case resp_odd=0.
- Timeout counter:
  - Cleared on entry to WAIT_BUSY; increments each cycle in WAIT_BUSY/WAIT_DONE.
  - Reaching TIMEOUT forces RESPOND with resp_err=1, resp_odd=0, p_start=0.
  - IDLE's p_busy==0 gate prevents issuing while the unit is still finishing.
- Latency:
  - Request seen in IDLE at cycle t -> grant at t+1.
  - done = 1 cycle after the p_busy fall is sampled.
- Arbitration and requester handshake:
  - req asserted during a transaction is ignored until IDLE.
  - A requester deasserting req before grant is simply not served.
  - Simultaneous requests are served one per transaction in round-robin order.
  - A requester re-requesting immediately after its done does not beat other pending requesters.
- Back-to-back transactions: at least one IDLE cycle between done and the next grant.
- grant and done are never asserted in the same cycle, and each is at most one-hot.
- Width: the timeout counter is clog2(TIMEOUT+1) bits and saturates; the pointer is clog2(NUM_REQ) bits and wraps NUM_REQ-1 -> 0.

Test Plan:
- Single request, with the real parity unit attached: req[1]=1, data=0x07 -> grant[1] pulse, p_data_in=0x07, later done[1] with resp_odd=1, resp_err=0. Repeat with data 0x0F -> resp_odd=0.
- Simultaneous requests: req=4'b0101, data0=0x01, data2=0x03 -> grant[0] first with done[0] resp_odd=1, then grant[2] with done[2] resp_odd=0. Next round with req=4'b0101 again -> grant[2]... actually order continues rr: grant[0] after grant[2].
- Fairness: req[3:0] all held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3. No requester granted twice while another waits.
- Timeout: p_busy model tied 0 -> p_start held high, done[i] with resp_err=1, resp_odd=0 exactly TIMEOUT cycles after grant+1. p_busy stuck 1 after a timeout -> no new grant until p_busy drops.
- Bad flags: unit model drops busy with p_even=p_odd=1 -> done with resp_err=1, resp_odd=0.
- Reset mid-operation: assert rst during WAIT_DONE -> next cycle all outputs 0, no done pulse. Pending req[0] granted first after rst release.
